// File: rtl/bcd_scan_counter_pkg.sv
// Package for the BCD scan counter: scan-state enum and digit constants,
// built on the shared bcd_defs.vh include.
package bcd_scan_counter_pkg;
  `include "bcd_defs.vh"

  typedef enum logic [1:0] {
    S_D0 = `S_D0,
    S_D1 = `S_D1,
    S_D2 = `S_D2,
    S_D3 = `S_D3
  } scan_state_t;

  localparam logic [3:0] BCD_MAX   = `BCD_MAX;
  localparam logic [3:0] BCD_BLANK = `BCD_BLANK;
  localparam int         NDIG      = `NDIG;

  // Out-of-range load digits collapse to zero; valid ones pass through.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction
endpackage

// File: rtl/bcd_defs.vh
// Shared constants for the BCD scan counter: scan-state encodings,
// the 7-segment decoder blank code, the largest BCD digit and the digit count.
`ifndef BCD_DEFS_VH
`define BCD_DEFS_VH

`define S_D0      2'd0
`define S_D1      2'd1
`define S_D2      2'd2
`define S_D3      2'd3
`define BCD_BLANK 4'b1111
`define BCD_MAX   4'd9
`define NDIG      4

`endif

// File: rtl/bcd_digit.sv
// One BCD digit cell of the count chain.
// Ports:
//   clk, rst    clock, async active-high reset
//   load        synchronous load (wins over step)
//   load_digit  raw digit to load; values above 9 load as 0
//   step        advance this digit (carry/borrow in from the less-significant cell)
//   up          1 = increment, 0 = decrement
//   q           current digit value, always 0..9
//   carry       carry (up) / borrow (down) out to the next cell
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up,
  output logic [3:0] q,
  output logic       carry
);

  // Ripples in the same cycle: this cell rolls over while it is stepping.
  assign carry = step && (up ? (q == BCD_MAX) : (q == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= 4'd0;
    else if (load) q <= bcd_sanitize(load_digit);
    else if (step) begin
      if (up) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a multiplexed 7-segment scan output.
// Parameter SCAN_DIV (1..255): cycles each digit stays selected.
// Ports:
//   clk, rst      clock, async active-high reset
//   en, up        count enable / direction (1 = up)
//   load,load_val synchronous load of four BCD digits (wins over en)
//   A,B,C,D       registered BCD code of the scanned digit (A = MSB)
//   dig_sel       one-hot digit strobe, bit0 = units
//   wrap          one-cycle pulse on 9999->0000 or 0000->9999
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits (never the
// units digit) are shown as the decoder blank code 1111.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic [3:0]  dig_sel,
  output logic        wrap
);

  localparam logic [7:0] PRESC_LAST = 8'(SCAN_DIV - 1);

  logic [NDIG-1:0][3:0] digits;
  logic [NDIG:0]        chain;

  // Count chain: the units cell steps on en; load suppresses every step.
  assign chain[0] = en & ~load;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .step       (chain[i]),
      .up         (up),
      .q          (digits[i]),
      .carry      (chain[i+1])
    );
  end

  // A carry out of the top digit is exactly a full-range wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= chain[NDIG];
  end

  // Scan FSM
  scan_state_t state, next_state;
  logic [7:0]  presc;
  logic        tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_D0;
      presc <= 8'd0;
    end else begin
      state <= next_state;
      presc <= tick ? 8'd0 : presc + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        S_D0:    next_state = S_D1;
        S_D1:    next_state = S_D2;
        S_D2:    next_state = S_D3;
        default: next_state = S_D0;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_D0:    dig_sel = 4'b0001;
      S_D1:    dig_sel = 4'b0010;
      S_D2:    dig_sel = 4'b0100;
      default: dig_sel = 4'b1000;
    endcase
  end

  // Display path: code of the selected digit, registered once.
  logic [3:0] sel_digit, disp, abcd;

  assign sel_digit = digits[state];

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digit i and every more-significant digit are zero.
  logic [NDIG-1:0] lead_zero;
  always_comb begin
    lead_zero[NDIG-1] = (digits[NDIG-1] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--)
      lead_zero[i] = lead_zero[i+1] && (digits[i] == 4'd0);
  end
  assign disp = (state != S_D0 && lead_zero[state]) ? BCD_BLANK : sel_digit;
`else
  assign disp = sel_digit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) abcd <= 4'd0;
    else     abcd <= disp;
  end

  assign {A, B, C, D} = abcd;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized self-checking bench for bcd_scan_counter against an integer
// reference model (count as 0..9999, scan position from cycles since reset).
module tb_bcd_scan_counter;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic        A, B, C, D, wrap;
  logic [3:0]  dig_sel;

  bcd_scan_counter #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .A(A), .B(B), .C(C), .D(D), .dig_sel(dig_sel), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model
  int       m_cnt = 0;
  int       m_n = 0;
  logic [3:0] m_abcd = 4'd0;
  logic     m_wrap = 1'b0;

  function automatic int pow10(input int k);
    case (k)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [3:0] exp_disp(input int cnt, input int st);
`ifdef LEADING_ZERO_BLANK_EN
    if (st > 0 && cnt < pow10(st)) return 4'hF;
`endif
    return 4'((cnt / pow10(st)) % 10);
  endfunction

  function automatic int sanitize(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      int d = int'((v >> (4 * i)) & 16'hF);
      if (d > 9) d = 0;
      r += d * pow10(i);
    end
    return r;
  endfunction

  function automatic int m_state();
    return (m_n / SD) % 4;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("dig_sel", {12'd0, dig_sel}, 16'(4'b0001 << m_state()));
    chk("abcd", {12'd0, A, B, C, D}, {12'd0, m_abcd});
    chk("wrap", {15'd0, wrap}, {15'd0, m_wrap});
  endtask

  task automatic model_reset();
    m_cnt = 0; m_n = 0; m_abcd = 4'd0; m_wrap = 1'b0;
  endtask

  // One clock: inputs already driven; update model from pre-edge values, check.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_abcd = exp_disp(m_cnt, m_state());
      m_wrap = 1'b0;
      if (load) m_cnt = sanitize(load_val);
      else if (en) begin
        if (up) begin m_wrap = (m_cnt == 9999); m_cnt = (m_cnt + 1) % 10000; end
        else    begin m_wrap = (m_cnt == 0);    m_cnt = (m_cnt + 9999) % 10000; end
      end
      m_n++;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic l, input logic [15:0] lv, input logic e, input logic u);
    load = l; load_val = lv; en = e; up = u;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 16'h0, 0, 1);
    #1;
    chk("rst_dig_sel", {12'd0, dig_sel}, 16'h0001);
    chk("rst_abcd", {12'd0, A, B, C, D}, 16'h0000);
    chk("rst_wrap", {15'd0, wrap}, 16'h0000);
    repeat (3) step();
    rst = 1'b0;

    // idle scan: two full rotations
    repeat (2 * 4 * SD) step();

    // 0009 + 1 -> 0010, then scan the digits
    drive(1, 16'h0009, 0, 1); step();
    drive(0, 16'h0, 1, 1);    step();
    drive(0, 16'h0, 0, 1);    repeat (4 * SD + 1) step();

    // up wrap, then down wrap
    drive(1, 16'h9999, 0, 1); step();
    drive(0, 16'h0, 1, 1);    step();
    drive(0, 16'h0, 0, 1);    repeat (2) step();
    drive(0, 16'h0, 1, 0);    step();
    drive(0, 16'h0, 0, 0);    repeat (4 * SD) step();

    // invalid digits and load/en together
    drive(1, 16'hA5F3, 0, 1); step();
    drive(1, 16'h0042, 1, 1); step();
    drive(0, 16'h0, 0, 1);    repeat (4 * SD + 1) step();
    drive(1, 16'h0000, 0, 1); step();
    drive(0, 16'h0, 0, 1);    repeat (4 * SD + 1) step();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      int r = int'($urandom_range(0, 99));
      logic [15:0] lv = 16'($urandom);
      if (r < 4)       lv = 16'h9999;
      else if (r < 8)  lv = 16'h0000;
      else if (r < 12) lv = 16'h9990 | 16'($urandom_range(0, 9));
      drive((r % 10) == 0 || r < 8, lv, 1'($urandom), 1'($urandom));
      step();
    end

    // async reset mid-scan during a wrap pulse in S_D2
    drive(1, 16'h9999, 0, 1); step();
    drive(0, 16'h0, 0, 1);
    for (int k = 0; k < 4 * SD + 1 && (((m_n + 1) / SD) % 4) != 2; k++) step();
    drive(0, 16'h0, 1, 1); step();
    chk("pre_rst_wrap", {15'd0, wrap}, 16'h0001);
    chk("pre_rst_sel", {12'd0, dig_sel}, 16'h0004);
    drive(0, 16'h0, 0, 1);
    #1 rst = 1'b1;
    #3;
    chk("async_dig_sel", {12'd0, dig_sel}, 16'h0001);
    chk("async_abcd", {12'd0, A, B, C, D}, 16'h0000);
    chk("async_wrap", {15'd0, wrap}, 16'h0000);
    rst = 1'b0;
    model_reset();
    repeat (4 * SD + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
